// File: rtl/ioblock_cfg_pkg.sv
// rtl/ioblock_cfg_pkg.sv - shared constants and types for the ioblock configuration controller
package ioblock_cfg_pkg;

    localparam int CFG_W = 3;

    localparam logic [1:0] TSMUX_HIZ   = 2'b00;
    localparam logic [1:0] TSMUX_TSCTL = 2'b01;
    localparam logic [1:0] TSMUX_DRIVE = 2'b10;

    // Safe power-up configuration: pad tri-stated, input path unregistered.
    localparam logic [1:0]       TSMUX_RST  = TSMUX_HIZ;
    localparam logic             DORREG_RST = 1'b0;
    localparam logic [CFG_W-1:0] CFG_RST    = {TSMUX_RST, DORREG_RST};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_COMMIT = 2'd2,
        ST_ERROR  = 2'd3
    } cfg_state_e;

endpackage

// File: rtl/iob_cfg_bank.sv
// rtl/iob_cfg_bank.sv - one pad's shadow/active configuration register pair
module iob_cfg_bank
    import ioblock_cfg_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [CFG_W-1:0] wr_data,
    input  logic             commit,
    output logic [1:0]       tsmux,
    output logic             dorreg
);

    logic [CFG_W-1:0] shadow_q, shadow_d;
    logic [CFG_W-1:0] active_q, active_d;

    // Shadow takes beats during load; active only moves on the shared commit strobe.
    always_comb begin
        shadow_d = wr_en  ? wr_data  : shadow_q;
        active_d = commit ? shadow_q : active_q;
    end

    // Both copies fall back to the safe configuration on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q <= CFG_RST;
            active_q <= CFG_RST;
        end else begin
            shadow_q <= shadow_d;
            active_q <= active_d;
        end
    end

    assign tsmux  = active_q[2:1];
    assign dorreg = active_q[0];

endmodule

// File: rtl/ioblock_cfg_ctrl.sv
// rtl/ioblock_cfg_ctrl.sv - collects per-pad config beats and commits all pads atomically
module ioblock_cfg_ctrl
    import ioblock_cfg_pkg::*;
#(
    parameter int NUM_IOB = 8,
    parameter int IDX_W   = $clog2(NUM_IOB)
) (
    input  logic                 IOCLK,
    input  logic                 RSTN,
    input  logic                 CFG_START,
    input  logic                 CFG_VALID,
    output logic                 CFG_READY,
    input  logic [CFG_W-1:0]     CFG_DATA,
    input  logic                 CFG_LAST,
    output logic [2*NUM_IOB-1:0] TSMUX_OUT,
    output logic [NUM_IOB-1:0]   DORREG_OUT,
    output logic                 BUSY,
    output logic                 DONE,
    output logic                 ERR
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_IOB - 1);

    cfg_state_e         state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               err_q, err_d;
    logic               done_q, done_d;
    logic               ready_q, ready_d;
    logic               busy_q, busy_d;
    logic [NUM_IOB-1:0] wr_en;
    logic               commit;

    // Sequencer: beat n lands in pad n; a restart drops the concurrent beat.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        err_d   = err_q;
        done_d  = 1'b0;
        wr_en   = '0;
        commit  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (CFG_START) begin
                    state_d = ST_LOAD;
                    idx_d   = '0;
                    err_d   = 1'b0;
                end
            end
            ST_LOAD: begin
                if (CFG_START) begin
                    idx_d = '0;
                end else if (CFG_VALID && ready_q) begin
                    wr_en[idx_q] = 1'b1;
                    if (CFG_LAST) begin
                        state_d = (idx_q == LAST_IDX) ? ST_COMMIT : ST_ERROR;
                    end else if (idx_q == LAST_IDX) begin
                        state_d = ST_ERROR;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            ST_COMMIT: begin
                commit  = 1'b1;
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            ST_ERROR: begin
                err_d   = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        // Status outputs are registered from the next-state so they track state_q exactly.
        ready_d = (state_d == ST_LOAD);
        busy_d  = (state_d == ST_LOAD) || (state_d == ST_COMMIT);
    end

    // Controller state and registered status outputs.
    always_ff @(posedge IOCLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
            done_q  <= done_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
        end
    end

    for (genvar i = 0; i < NUM_IOB; i++) begin : g_bank
        iob_cfg_bank u_bank (
            .clk     (IOCLK),
            .rst_n   (RSTN),
            .wr_en   (wr_en[i]),
            .wr_data (CFG_DATA),
            .commit  (commit),
            .tsmux   (TSMUX_OUT[2*i+1:2*i]),
            .dorreg  (DORREG_OUT[i])
        );
    end

    assign CFG_READY = ready_q;
    assign BUSY      = busy_q;
    assign DONE      = done_q;
    assign ERR       = err_q;

endmodule

// File: tb/tb_ioblock_cfg_ctrl.sv
// tb/tb_ioblock_cfg_ctrl.sv - scoreboard testbench for ioblock_cfg_ctrl
module tb_ioblock_cfg_ctrl;

    localparam int NUM_IOB = 8;

    logic                 IOCLK = 1'b0;
    logic                 RSTN;
    logic                 CFG_START;
    logic                 CFG_VALID;
    logic                 CFG_READY;
    logic [2:0]           CFG_DATA;
    logic                 CFG_LAST;
    logic [2*NUM_IOB-1:0] TSMUX_OUT;
    logic [NUM_IOB-1:0]   DORREG_OUT;
    logic                 BUSY;
    logic                 DONE;
    logic                 ERR;

    ioblock_cfg_ctrl #(.NUM_IOB(NUM_IOB)) dut (
        .IOCLK      (IOCLK),
        .RSTN       (RSTN),
        .CFG_START  (CFG_START),
        .CFG_VALID  (CFG_VALID),
        .CFG_READY  (CFG_READY),
        .CFG_DATA   (CFG_DATA),
        .CFG_LAST   (CFG_LAST),
        .TSMUX_OUT  (TSMUX_OUT),
        .DORREG_OUT (DORREG_OUT),
        .BUSY       (BUSY),
        .DONE       (DONE),
        .ERR        (ERR)
    );

    always #5 IOCLK = ~IOCLK;

    typedef logic [23:0] cfg_t;   // {tsmux[15:0], dorreg[7:0]}

    cfg_t        sb_q[$];
    int          tests_run = 0;
    int          tests_failed = 0;
    logic [2:0]  pat [NUM_IOB];
    logic [15:0] act_ts;
    logic [7:0]  act_dr;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic cfg_t model_of_pat();
        cfg_t r;
        r = '0;
        for (int i = 0; i < NUM_IOB; i++) begin
            r[8 + 2*i +: 2] = pat[i][2:1];
            r[i]            = pat[i][0];
        end
        return r;
    endfunction

    // Pop the expected configuration whenever the DUT reports a commit.
    always @(negedge IOCLK) begin
        if (RSTN && DONE) begin
            if (sb_q.size() == 0) begin
                check_val("unexpected_done", 32'd1, 32'd0);
            end else begin
                cfg_t e;
                e = sb_q.pop_front();
                check_val("commit_tsmux", TSMUX_OUT, e[23:8]);
                check_val("commit_dorreg", DORREG_OUT, e[7:0]);
            end
        end
    end

    task automatic pulse_start();
        CFG_START = 1'b1;
        @(negedge IOCLK);
        CFG_START = 1'b0;
    endtask

    task automatic beat(input logic [2:0] d, input logic last, input int gap);
        int n;
        for (int g = 0; g < gap; g++) begin
            CFG_VALID = 1'b0;
            CFG_DATA  = 3'($urandom);
            @(negedge IOCLK);
        end
        CFG_VALID = 1'b1;
        CFG_DATA  = d;
        CFG_LAST  = last;
        n = 0;
        while (!CFG_READY && n < 20) begin
            @(negedge IOCLK);
            n++;
        end
        if (n == 20) begin
            check_val("ready_timeout", 32'd0, 32'd1);
        end else begin
            @(negedge IOCLK);
        end
        CFG_VALID = 1'b0;
        CFG_LAST  = 1'b0;
    endtask

    task automatic run_seq(input bit rnd_gap, input bit do_start);
        if (do_start) pulse_start();
        for (int i = 0; i < NUM_IOB; i++) begin
            if (i == NUM_IOB - 1) sb_q.push_back(model_of_pat());
            beat(pat[i], i == NUM_IOB - 1, rnd_gap ? int'($urandom_range(0, 3)) : 0);
            if (i < NUM_IOB - 1) begin
                check_val("hold_tsmux", TSMUX_OUT, act_ts);
                check_val("hold_dorreg", DORREG_OUT, act_dr);
            end
        end
    endtask

    // Called in the COMMIT cycle: outputs switch exactly one edge later.
    task automatic expect_commit();
        cfg_t e;
        e = model_of_pat();
        check_val("pre_commit_done", DONE, 1'b0);
        check_val("pre_commit_busy", BUSY, 1'b1);
        check_val("pre_commit_tsmux", TSMUX_OUT, act_ts);
        @(negedge IOCLK);
        check_val("commit_done", DONE, 1'b1);
        act_ts = e[23:8];
        act_dr = e[7:0];
        @(negedge IOCLK);
        check_val("post_commit_done", DONE, 1'b0);
        check_val("post_commit_busy", BUSY, 1'b0);
        check_val("post_commit_tsmux", TSMUX_OUT, act_ts);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] ii;
        RSTN      = 1'b0;
        CFG_START = 1'b0;
        CFG_VALID = 1'b0;
        CFG_DATA  = '0;
        CFG_LAST  = 1'b0;
        act_ts    = '0;
        act_dr    = '0;
        repeat (3) @(negedge IOCLK);
        RSTN = 1'b1;
        @(negedge IOCLK);

        check_val("rst_tsmux", TSMUX_OUT, 16'h0000);
        check_val("rst_dorreg", DORREG_OUT, 8'h00);
        check_val("rst_ready", CFG_READY, 1'b0);
        check_val("rst_busy", BUSY, 1'b0);
        check_val("rst_done", DONE, 1'b0);
        check_val("rst_err", ERR, 1'b0);

        // Incrementing pattern, includes TSMUX=2'b11.
        for (int i = 0; i < NUM_IOB; i++) begin
            ii = 3'(i);
            pat[i] = {ii[1:0], ii[0]};
        end
        run_seq(1'b0, 1'b1);
        expect_commit();
        check_val("t1_tsmux_const", TSMUX_OUT, 16'hE4E4);
        check_val("t1_dorreg_const", DORREG_OUT, 8'hAA);

        // Random VALID gaps, all TSCTL with DORREG set.
        for (int i = 0; i < NUM_IOB; i++) pat[i] = 3'b011;
        run_seq(1'b1, 1'b1);
        expect_commit();
        check_val("t2_tsmux_const", TSMUX_OUT, 16'h5555);
        check_val("t2_dorreg_const", DORREG_OUT, 8'hFF);

        // Short sequence: LAST on beat 4.
        pulse_start();
        for (int i = 0; i < 5; i++) beat(3'b100, i == 4, 0);
        @(negedge IOCLK);
        check_val("short_err", ERR, 1'b1);
        check_val("short_done", DONE, 1'b0);
        check_val("short_busy", BUSY, 1'b0);
        check_val("short_tsmux", TSMUX_OUT, act_ts);
        check_val("short_dorreg", DORREG_OUT, act_dr);
        pulse_start();
        check_val("start_clears_err", ERR, 1'b0);
        check_val("start_ready", CFG_READY, 1'b1);

        // Long sequence: 8 beats, no LAST, continuing the load just started.
        for (int i = 0; i < NUM_IOB; i++) beat(3'b101, 1'b0, 0);
        CFG_VALID = 1'b1;
        check_val("long_ready_9th", CFG_READY, 1'b0);
        @(negedge IOCLK);
        check_val("long_err", ERR, 1'b1);
        check_val("long_ready_idle", CFG_READY, 1'b0);
        CFG_VALID = 1'b0;
        check_val("long_tsmux", TSMUX_OUT, act_ts);
        check_val("long_dorreg", DORREG_OUT, act_dr);

        // Restart mid-load with a concurrent (dropped) LAST beat.
        pulse_start();
        for (int i = 0; i < 3; i++) beat(3'b111, 1'b0, 0);
        CFG_START = 1'b1;
        CFG_VALID = 1'b1;
        CFG_DATA  = 3'b110;
        CFG_LAST  = 1'b1;
        @(negedge IOCLK);
        CFG_START = 1'b0;
        CFG_VALID = 1'b0;
        CFG_LAST  = 1'b0;
        for (int i = 0; i < NUM_IOB; i++) pat[i] = 3'($urandom);
        run_seq(1'b1, 1'b0);
        expect_commit();
        check_val("restart_err", ERR, 1'b0);

        // Asynchronous reset mid-load.
        pulse_start();
        for (int i = 0; i < 3; i++) beat(3'b010, 1'b0, 0);
        #2;
        RSTN = 1'b0;
        #1;
        check_val("arst_tsmux", TSMUX_OUT, 16'h0000);
        check_val("arst_dorreg", DORREG_OUT, 8'h00);
        check_val("arst_busy", BUSY, 1'b0);
        check_val("arst_ready", CFG_READY, 1'b0);
        act_ts = '0;
        act_dr = '0;
        @(negedge IOCLK);
        @(negedge IOCLK);
        RSTN = 1'b1;
        CFG_VALID = 1'b1;
        @(negedge IOCLK);
        check_val("arst_idle_ready", CFG_READY, 1'b0);
        check_val("arst_idle_busy", BUSY, 1'b0);
        CFG_VALID = 1'b0;

        // Full load after reset still works.
        for (int i = 0; i < NUM_IOB; i++) pat[i] = 3'(NUM_IOB - 1 - i);
        run_seq(1'b0, 1'b1);
        expect_commit();

        repeat (2) @(negedge IOCLK);
        check_val("sb_empty", sb_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
